// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the 8-way mux arbiter
//
// Contents:
//   arbState_t  : arbiter state encoding (IDLE=0, OWN=1)
//   N_REQ       : number of requesters (8)
//   IDX_W       : width of a requester index (3)
//   selEncode() : requester index -> bit-reversed mux select
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arbState_t;

  // The downstream 8:1 mux has its select bits wired in reverse order.
  function automatic logic [IDX_W-1:0] selEncode(input logic [IDX_W-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin winner search over 8 requesters
//
// Ports:
//   req   in  [7:0] request lines
//   ptr   in  [2:0] index of the last owner; the search starts at ptr+1
//   valid out       at least one request is set
//   idx   out [2:0] first set request at or after ptr+1, wrapping modulo 8
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Index arithmetic wraps naturally at IDX_W bits.
      cand = ptr + IDX_W'(k + 1);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter8.sv
// rtl/mux_arbiter8.sv - round-robin arbiter driving the select of an 8:1 mux
//
// Ports:
//   clk    in       single clock, rising edge
//   reset  in       asynchronous active-high reset
//   req    in  [7:0] request lines, req[i] feeds mux data input i
//   done   in       current owner ends its transfer
//   gnt    out [7:0] registered one-hot grant
//   sel    out [2:0] registered bit-reversed mux select, sticky across idle
//   busy   out      a grant is active
//
// Build option: define ARB_TIMEOUT_EN to force release after MAX_HOLD owned
// cycles while another requester is waiting.
module mux_arbiter8
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] sel,
  output logic             busy
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : gBadHold
    $error("mux_arbiter8: MAX_HOLD must be in 1..15");
  end

  arbState_t        state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ownerIdx;
  logic             pickValid;
  logic [IDX_W-1:0] pickIdx;
  logic             holdExpired;
  logic             relNow;

  rr_pick8 uPick (
    .req   (req),
    .ptr   (ptr),
    .valid (pickValid),
    .idx   (pickIdx)
  );

`ifdef ARB_TIMEOUT_EN
  // holdCnt counts completed owned cycles minus one; it saturates at
  // MAX_HOLD-1 so a lone owner keeps the bus until someone else asks.
  logic [3:0] holdCnt;
  assign holdExpired = (holdCnt == 4'(MAX_HOLD - 1)) && |(req & ~gnt);
`else
  assign holdExpired = 1'b0;
`endif

  // Non-owner request changes do not matter here; only the owner's own bit.
  assign relNow = done || !req[ownerIdx] || holdExpired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      ptr      <= IDX_W'(N_REQ - 1);
      ownerIdx <= '0;
`ifdef ARB_TIMEOUT_EN
      holdCnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pickValid) begin
            state    <= OWN;
            gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << pickIdx;
            sel      <= selEncode(pickIdx);
            busy     <= 1'b1;
            ownerIdx <= pickIdx;
`ifdef ARB_TIMEOUT_EN
            holdCnt  <= '0;
`endif
          end
        end
        OWN: begin
          if (relNow) begin
            // sel is left alone so the mux never moves mid-grant.
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= ownerIdx;
          end
`ifdef ARB_TIMEOUT_EN
          else if (holdCnt != 4'(MAX_HOLD - 1)) begin
            holdCnt <= holdCnt + 4'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter8.sv
// tb/tb_mux_arbiter8.sv - directed scoreboard bench for mux_arbiter8
//
// Ports: none (top-level bench). Honors ARB_TIMEOUT_EN like the design.
module tb_mux_arbiter8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  int nAsserts = 0;
  int nFails   = 0;

  logic [11:0] expQ[$];
  logic [2:0]  selTab[8] = '{3'b000, 3'b100, 3'b010, 3'b110,
                             3'b001, 3'b101, 3'b011, 3'b111};

  mux_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .done  (done),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $error("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic checkOut(input string tag);
    logic [11:0] expV;
    logic [11:0] obsV;
    nAsserts++;
    if (expQ.size() == 0) begin
      nFails++;
      $error("FAIL %s: observed empty scoreboard, expected an entry", tag);
    end else begin
      expV = expQ.pop_front();
      obsV = {gnt, sel, busy};
      assert (obsV === expV) else begin
        nFails++;
        $error("FAIL %s: observed gnt=%h sel=%b busy=%b, expected gnt=%h sel=%b busy=%b",
               tag, obsV[11:4], obsV[3:1], obsV[0], expV[11:4], expV[3:1], expV[0]);
      end
    end
  endtask

  // Drive one cycle of inputs, record what must appear after the next edge.
  task automatic step(input string tag, input logic [7:0] r, input logic d,
                      input logic [7:0] eg, input logic [2:0] es, input logic eb);
    req  = r;
    done = d;
    expQ.push_back({eg, es, eb});
    @(posedge clk);
    #1;
    checkOut(tag);
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expQ.push_back({8'h00, 3'b000, 1'b0});
    checkOut("reset_state");
    reset = 1'b0;

    // Single requesters and select encoding
    step("grant_a",      8'h01, 1'b0, 8'h01, 3'b000, 1'b1);
    step("done_a",       8'h01, 1'b1, 8'h00, 3'b000, 1'b0);
    step("grant_b",      8'h02, 1'b0, 8'h02, 3'b100, 1'b1);
    step("drop_b",       8'h00, 1'b0, 8'h00, 3'b100, 1'b0);
    step("grant_d",      8'h08, 1'b0, 8'h08, 3'b110, 1'b1);
    step("done_d",       8'h08, 1'b1, 8'h00, 3'b110, 1'b0);
    step("grant_h",      8'h80, 1'b0, 8'h80, 3'b111, 1'b1);
    step("done_h",       8'h80, 1'b1, 8'h00, 3'b111, 1'b0);

    // Full round-robin rotation, one bubble cycle between grants
    for (int i = 0; i < 9; i++) begin
      step($sformatf("rr_grant%0d", i), 8'hFF, 1'b0, 8'h01 << (i % 8), selTab[i % 8], 1'b1);
      step($sformatf("rr_bubble%0d", i), 8'hFF, 1'b1, 8'h00, selTab[i % 8], 1'b0);
    end

    // done in IDLE has no effect
    step("idle_done",    8'h00, 1'b1, 8'h00, 3'b000, 1'b0);

    // Non-owner request changes during OWN are ignored
    step("grant_c",      8'h04, 1'b0, 8'h04, 3'b010, 1'b1);
    step("hold_c_6",     8'h06, 1'b0, 8'h04, 3'b010, 1'b1);
    step("hold_c_5",     8'h05, 1'b0, 8'h04, 3'b010, 1'b1);
    step("done_c",       8'h04, 1'b1, 8'h00, 3'b010, 1'b0);

    // Hold limit with a competitor waiting (ptr=2, so 0 wins first)
    step("to_grant0",    8'h05, 1'b0, 8'h01, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++)
      step($sformatf("to_hold%0d", k), 8'h05, 1'b0, 8'h01, 3'b000, 1'b1);
`ifdef ARB_TIMEOUT_EN
    step("to_release",   8'h05, 1'b0, 8'h00, 3'b000, 1'b0);
`else
    step("no_timeout",   8'h05, 1'b0, 8'h01, 3'b000, 1'b1);
    step("to_done",      8'h05, 1'b1, 8'h00, 3'b000, 1'b0);
`endif
    step("to_grant2",    8'h05, 1'b0, 8'h04, 3'b010, 1'b1);
    step("to_done2",     8'h05, 1'b1, 8'h00, 3'b010, 1'b0);

    // Sole requester equal to last owner is granted again
    step("regrant_c",    8'h04, 1'b0, 8'h04, 3'b010, 1'b1);
    step("regrant_done", 8'h04, 1'b1, 8'h00, 3'b010, 1'b0);

    // Owner drops its request; next search starts after it
    step("grant_d2",     8'h18, 1'b0, 8'h08, 3'b110, 1'b1);
    step("drop_d2",      8'h10, 1'b0, 8'h00, 3'b110, 1'b0);
    step("after_drop",   8'h19, 1'b0, 8'h10, 3'b001, 1'b1);
    step("done_e",       8'h19, 1'b1, 8'h00, 3'b001, 1'b0);

    // Asynchronous reset mid-grant
    step("grant_f",      8'h20, 1'b0, 8'h20, 3'b101, 1'b1);
    #2 reset = 1'b1;
    #1;
    expQ.push_back({8'h00, 3'b000, 1'b0});
    checkOut("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset",   8'h21, 1'b0, 8'h01, 3'b000, 1'b1);
    step("post_done",    8'h21, 1'b1, 8'h00, 3'b000, 1'b0);

    nAsserts++;
    assert (expQ.size() == 0) else begin
      nFails++;
      $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
